// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants, also used by the control unit.
package fetch_pkg;

    localparam int unsigned XLEN     = 64;
    localparam int unsigned ILEN     = 32;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        FULL  = 2'd2,
        FAULT = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit.sv
// Fetch stage of the RV64 multicycle core: PC register, single-outstanding
// instruction-memory requests and the instruction register feeding decode.
module instr_fetch_unit #(
    parameter int unsigned    XLEN     = fetch_pkg::XLEN,
    parameter int unsigned    ILEN     = fetch_pkg::ILEN,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [ILEN-1:0] imem_rdata,
    output logic [ILEN-1:0] ir,
    output logic [XLEN-1:0] ir_pc,
    output logic            ir_valid,
    input  logic            ir_ready,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            fault
);

    import fetch_pkg::*;

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            discard_q, discard_d;
    logic            ir_load;
    logic            misaligned;

    assign misaligned = (redirect_pc[1:0] != 2'b00);

    // State, PC, IR and discard flag registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            pc_q      <= RESET_PC;
            ir        <= ILEN'(NOP_INST);
            ir_pc     <= '0;
            discard_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            discard_q <= discard_d;
            if (ir_load) begin
                ir    <= imem_rdata;
                ir_pc <= pc_q;
            end
        end
    end

    // Next state; redirect outranks everything except the sticky fault
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        discard_d = discard_q;
        ir_load   = 1'b0;
        unique case (state_q)
            FETCH: begin
                if (redirect) begin
                    if (misaligned) begin
                        state_d   = FAULT;
                        discard_d = 1'b0;
                    end else begin
                        pc_d = redirect_pc;
                        if (imem_ready) begin
                            state_d   = WAIT;
                            discard_d = 1'b1;
                        end
                    end
                end else if (imem_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (redirect) begin
                    if (misaligned) begin
                        state_d   = FAULT;
                        discard_d = 1'b0;
                    end else begin
                        pc_d = redirect_pc;
                        if (imem_rvalid) begin
                            state_d   = FETCH;
                            discard_d = 1'b0;
                        end else begin
                            discard_d = 1'b1;
                        end
                    end
                end else if (imem_rvalid) begin
                    if (discard_q) begin
                        state_d   = FETCH;
                        discard_d = 1'b0;
                    end else begin
                        ir_load = 1'b1;
                        pc_d    = pc_q + XLEN'(4);
                        state_d = FULL;
                    end
                end
            end
            FULL: begin
                if (redirect) begin
                    if (misaligned) begin
                        state_d = FAULT;
                    end else begin
                        pc_d    = redirect_pc;
                        state_d = FETCH;
                    end
                    discard_d = 1'b0;
                end else if (ir_ready) begin
                    state_d = FETCH;
                end
            end
            FAULT: begin
                discard_d = 1'b0;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // Outputs decoded from the registered state
    always_comb begin
        imem_req  = rst_n && (state_q == FETCH);
        imem_addr = pc_q;
        ir_valid  = (state_q == FULL);
        fault     = (state_q == FAULT);
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit with a timing-driven memory stub
// and a PC/IR reference model kept in plain bench variables.
module tb_instr_fetch_unit;

    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [63:0] TOPPC = 64'hFFFF_FFFF_FFFF_FFFC;

    logic        clk;
    logic        rst_n;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        ir_ready;
    logic        redirect;
    logic [63:0] redirect_pc;

    logic        imem_req,   d2_imem_req;
    logic [63:0] imem_addr,  d2_imem_addr;
    logic [31:0] ir,         d2_ir;
    logic [63:0] ir_pc,      d2_ir_pc;
    logic        ir_valid,   d2_ir_valid;
    logic        fault,      d2_fault;

    int checks;
    int failures;
    logic [63:0] exp_pc;

    instr_fetch_unit u_dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid), .ir_ready(ir_ready),
        .redirect(redirect), .redirect_pc(redirect_pc), .fault(fault)
    );

    instr_fetch_unit #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) u_dut_top (
        .clk(clk), .rst_n(rst_n),
        .imem_req(d2_imem_req), .imem_addr(d2_imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .ir(d2_ir), .ir_pc(d2_ir_pc), .ir_valid(d2_ir_valid), .ir_ready(ir_ready),
        .redirect(redirect), .redirect_pc(redirect_pc), .fault(d2_fault)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] rand_aligned();
        logic [63:0] v;
        v = {32'($urandom), 32'($urandom)};
        v[1:0] = 2'b00;
        return v;
    endfunction

    // Wait (bounded) until the DUT is requesting
    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (imem_req) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    // One complete memory transaction: accept, then respond after lat cycles
    task automatic mem_txn(input int lat, input logic [31:0] data,
                           output logic [63:0] addr, output bit ok);
        wait_req(ok);
        addr = imem_addr;
        if (!ok) return;
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        repeat (lat - 1) step();
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        step();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'($urandom);
    endtask

    task automatic consume();
        ir_ready = 1'b1;
        step();
        ir_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++;
        if (imem_req !== 1'b0) begin
            failures++; $display("FAIL reset_req_low got=%b exp=0", imem_req);
        end
        checks++;
        if (ir !== NOP || ir_pc !== 64'h0 || ir_valid !== 1'b0 || fault !== 1'b0) begin
            failures++;
            $display("FAIL reset_regs got ir=%h ir_pc=%h v=%b f=%b exp ir=%h ir_pc=0 v=0 f=0",
                     ir, ir_pc, ir_valid, fault, NOP);
        end
        checks++;
        if (imem_addr !== 64'h0 || d2_imem_addr !== TOPPC) begin
            failures++;
            $display("FAIL reset_pc got=%h/%h exp=0/%h", imem_addr, d2_imem_addr, TOPPC);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b1) begin
            failures++; $display("FAIL reset_release_req got=%b exp=1", imem_req);
        end
        exp_pc = 64'h0;
    endtask

    task automatic test_basic_fetch();
        logic [63:0] addr;
        bit ok;
        mem_txn(2, 32'h0050_0093, addr, ok);
        checks++;
        if (!ok || addr !== 64'h0) begin
            failures++; $display("FAIL basic_addr ok=%b got=%h exp=0", ok, addr);
        end
        checks++;
        if (ir !== 32'h0050_0093 || ir_pc !== 64'h0 || ir_valid !== 1'b1 || imem_req !== 1'b0) begin
            failures++;
            $display("FAIL basic_ir got ir=%h pc=%h v=%b req=%b exp ir=00500093 pc=0 v=1 req=0",
                     ir, ir_pc, ir_valid, imem_req);
        end
        checks++;
        if (d2_ir_pc !== TOPPC) begin
            failures++; $display("FAIL wrap_ir_pc got=%h exp=%h", d2_ir_pc, TOPPC);
        end
        consume();
        exp_pc = exp_pc + 64'd4;
        checks++;
        if (ir_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== exp_pc) begin
            failures++;
            $display("FAIL basic_next got v=%b req=%b addr=%h exp v=0 req=1 addr=%h",
                     ir_valid, imem_req, imem_addr, exp_pc);
        end
        checks++;
        if (d2_imem_addr !== 64'h0) begin
            failures++; $display("FAIL wrap_pc got=%h exp=0", d2_imem_addr);
        end
    endtask

    task automatic test_hold();
        logic [63:0] addr;
        logic [31:0] data;
        bit ok;
        data = 32'($urandom);
        mem_txn(int'($urandom_range(1, 4)), data, addr, ok);
        checks++;
        if (!ok || addr !== exp_pc || ir !== data) begin
            failures++; $display("FAIL hold_load ok=%b addr=%h ir=%h exp addr=%h ir=%h",
                                 ok, addr, ir, exp_pc, data);
        end
        for (int i = 0; i < 10; i++) begin
            imem_rvalid = 1'($urandom_range(0, 1));
            imem_rdata  = 32'($urandom);
            imem_ready  = 1'($urandom_range(0, 1));
            step();
            checks++;
            if (ir !== data || ir_pc !== exp_pc || ir_valid !== 1'b1 || imem_req !== 1'b0 ||
                imem_addr !== exp_pc + 64'd4) begin
                failures++;
                $display("FAIL hold_stable cyc=%0d got ir=%h pc=%h v=%b req=%b addr=%h exp ir=%h pc=%h",
                         i, ir, ir_pc, ir_valid, imem_req, imem_addr, data, exp_pc);
            end
        end
        imem_rvalid = 1'b0;
        imem_ready  = 1'b0;
        consume();
        exp_pc = exp_pc + 64'd4;
        checks++;
        if (imem_addr !== exp_pc || imem_req !== 1'b1) begin
            failures++; $display("FAIL hold_next got=%h req=%b exp=%h", imem_addr, imem_req, exp_pc);
        end
    endtask

    task automatic test_random_stream();
        logic [63:0] addr;
        logic [31:0] data;
        bit ok;
        for (int n = 0; n < 16; n++) begin
            data = 32'($urandom);
            mem_txn(int'($urandom_range(1, 5)), data, addr, ok);
            checks++;
            if (!ok || addr !== exp_pc || ir !== data || ir_pc !== exp_pc || ir_valid !== 1'b1) begin
                failures++;
                $display("FAIL stream n=%0d ok=%b addr=%h ir=%h ir_pc=%h v=%b exp addr=%h ir=%h",
                         n, ok, addr, ir, ir_pc, ir_valid, exp_pc, data);
            end
            repeat ($urandom_range(0, 3)) step();
            consume();
            exp_pc = exp_pc + 64'd4;
        end
        checks++;
        if (imem_addr !== exp_pc) begin
            failures++; $display("FAIL stream_end_pc got=%h exp=%h", imem_addr, exp_pc);
        end
    endtask

    task automatic test_redirect_wait();
        logic [63:0] addr;
        logic [31:0] data;
        bit ok;
        wait_req(ok);
        imem_ready = 1'b1;
        step();
        imem_ready  = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 64'h100;
        step();
        redirect = 1'b0;
        checks++;
        if (!ok || ir_valid !== 1'b0 || imem_req !== 1'b0) begin
            failures++; $display("FAIL rdw_wait ok=%b v=%b req=%b exp v=0 req=0", ok, ir_valid, imem_req);
        end
        step();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'($urandom);
        step();
        imem_rvalid = 1'b0;
        exp_pc = 64'h100;
        checks++;
        if (ir_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== exp_pc) begin
            failures++; $display("FAIL rdw_drop v=%b req=%b addr=%h exp v=0 req=1 addr=%h",
                                 ir_valid, imem_req, imem_addr, exp_pc);
        end
        data = 32'($urandom);
        mem_txn(1, data, addr, ok);
        checks++;
        if (!ok || addr !== exp_pc || ir !== data || ir_pc !== exp_pc) begin
            failures++; $display("FAIL rdw_after addr=%h ir=%h exp addr=%h ir=%h", addr, ir, exp_pc, data);
        end
        consume();
        exp_pc = exp_pc + 64'd4;
    endtask

    task automatic test_redirect_same_cycle();
        logic [63:0] addr, tgt;
        logic [31:0] data;
        bit ok;
        tgt = rand_aligned();
        wait_req(ok);
        imem_ready = 1'b1;
        step();
        imem_ready  = 1'b0;
        redirect    = 1'b1;
        redirect_pc = tgt;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'($urandom);
        step();
        redirect    = 1'b0;
        imem_rvalid = 1'b0;
        exp_pc = tgt;
        checks++;
        if (!ok || ir_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== exp_pc) begin
            failures++; $display("FAIL rsc_state ok=%b v=%b req=%b addr=%h exp v=0 req=1 addr=%h",
                                 ok, ir_valid, imem_req, imem_addr, exp_pc);
        end
        data = 32'($urandom);
        mem_txn(2, data, addr, ok);
        checks++;
        if (!ok || addr !== exp_pc || ir !== data || ir_valid !== 1'b1) begin
            failures++; $display("FAIL rsc_after addr=%h ir=%h v=%b exp addr=%h ir=%h v=1",
                                 addr, ir, ir_valid, exp_pc, data);
        end
        consume();
        exp_pc = exp_pc + 64'd4;
    endtask

    task automatic test_redirect_fetch_full();
        logic [63:0] addr, tgt, tgt2;
        logic [31:0] data;
        bit ok;
        tgt = rand_aligned();
        wait_req(ok);
        imem_ready  = 1'b1;
        redirect    = 1'b1;
        redirect_pc = tgt;
        step();
        imem_ready = 1'b0;
        redirect   = 1'b0;
        checks++;
        if (!ok || imem_req !== 1'b0 || ir_valid !== 1'b0) begin
            failures++; $display("FAIL rfa_stale ok=%b req=%b v=%b exp req=0 v=0", ok, imem_req, ir_valid);
        end
        repeat ($urandom_range(0, 2)) step();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'($urandom);
        step();
        imem_rvalid = 1'b0;
        exp_pc = tgt;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== exp_pc || ir_valid !== 1'b0) begin
            failures++; $display("FAIL rfa_drop req=%b addr=%h v=%b exp req=1 addr=%h v=0",
                                 imem_req, imem_addr, ir_valid, exp_pc);
        end
        data = 32'($urandom);
        mem_txn(1, data, addr, ok);
        tgt2 = rand_aligned();
        redirect    = 1'b1;
        redirect_pc = tgt2;
        step();
        redirect = 1'b0;
        exp_pc = tgt2;
        checks++;
        if (!ok || addr !== tgt || ir_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== exp_pc) begin
            failures++; $display("FAIL rfull addr=%h v=%b req=%b pc=%h exp addr=%h v=0 req=1 pc=%h",
                                 addr, ir_valid, imem_req, imem_addr, tgt, exp_pc);
        end
    endtask

    task automatic test_pc_wrap();
        logic [63:0] addr;
        logic [31:0] data;
        bit ok;
        wait_req(ok);
        imem_ready  = 1'b0;
        redirect    = 1'b1;
        redirect_pc = TOPPC;
        step();
        redirect = 1'b0;
        checks++;
        if (!ok || imem_req !== 1'b1 || imem_addr !== TOPPC) begin
            failures++; $display("FAIL wrap_redirect req=%b addr=%h exp req=1 addr=%h", imem_req, imem_addr, TOPPC);
        end
        data = 32'($urandom);
        mem_txn(3, data, addr, ok);
        checks++;
        if (!ok || ir_pc !== TOPPC || ir !== data) begin
            failures++; $display("FAIL wrap_ir ir_pc=%h ir=%h exp ir_pc=%h ir=%h", ir_pc, ir, TOPPC, data);
        end
        consume();
        exp_pc = TOPPC + 64'd4;
        checks++;
        if (imem_addr !== 64'h0) begin
            failures++; $display("FAIL wrap_zero got=%h exp=0", imem_addr);
        end
    endtask

    task automatic test_fault();
        logic [63:0] held;
        bit ok;
        wait_req(ok);
        held        = imem_addr;
        redirect    = 1'b1;
        redirect_pc = 64'h102;
        step();
        redirect = 1'b0;
        checks++;
        if (!ok || fault !== 1'b1 || imem_req !== 1'b0 || ir_valid !== 1'b0 || imem_addr !== held) begin
            failures++; $display("FAIL fault_enter f=%b req=%b v=%b pc=%h exp f=1 req=0 v=0 pc=%h",
                                 fault, imem_req, ir_valid, imem_addr, held);
        end
        for (int i = 0; i < 10; i++) begin
            redirect    = 1'($urandom_range(0, 1));
            redirect_pc = rand_aligned();
            imem_ready  = 1'($urandom_range(0, 1));
            imem_rvalid = 1'($urandom_range(0, 1));
            imem_rdata  = 32'($urandom);
            ir_ready    = 1'($urandom_range(0, 1));
            step();
            checks++;
            if (fault !== 1'b1 || imem_req !== 1'b0 || ir_valid !== 1'b0 || imem_addr !== held) begin
                failures++; $display("FAIL fault_sticky cyc=%0d f=%b req=%b v=%b pc=%h", i,
                                     fault, imem_req, ir_valid, imem_addr);
            end
        end
        redirect = 1'b0; imem_ready = 1'b0; imem_rvalid = 1'b0; ir_ready = 1'b0;
        rst_n = 1'b0;
        step();
        checks++;
        if (fault !== 1'b0 || imem_req !== 1'b0 || imem_addr !== 64'h0 || d2_fault !== 1'b0 ||
            d2_imem_addr !== TOPPC) begin
            failures++; $display("FAIL fault_clear f=%b req=%b pc=%h f2=%b pc2=%h exp f=0 req=0 pc=0",
                                 fault, imem_req, imem_addr, d2_fault, d2_imem_addr);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b1) begin
            failures++; $display("FAIL fault_restart req=%b exp=1", imem_req);
        end
        exp_pc = 64'h0;
    endtask

    task automatic test_reset_mid_wait();
        logic [63:0] addr;
        logic [31:0] data;
        bit ok;
        data = 32'($urandom);
        mem_txn(1, data, addr, ok);
        consume();
        wait_req(ok);
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
        checks++;
        if (!ok || ir_valid !== 1'b0 || ir !== NOP || ir_pc !== 64'h0 || imem_req !== 1'b1 ||
            imem_addr !== 64'h0) begin
            failures++; $display("FAIL rst_wait v=%b ir=%h ir_pc=%h req=%b pc=%h exp v=0 ir=%h req=1 pc=0",
                                 ir_valid, ir, ir_pc, imem_req, imem_addr, NOP);
        end
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        step();
        imem_rvalid = 1'b0;
        checks++;
        if (ir_valid !== 1'b0 || ir !== NOP || imem_req !== 1'b1) begin
            failures++; $display("FAIL rst_stale v=%b ir=%h req=%b exp v=0 ir=%h req=1",
                                 ir_valid, ir, imem_req, NOP);
        end
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        exp_pc      = '0;
        rst_n       = 1'b0;
        imem_ready  = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        ir_ready    = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        test_reset();
        test_basic_fetch();
        test_hold();
        test_random_stream();
        test_redirect_wait();
        test_redirect_same_cycle();
        test_redirect_fetch_full();
        test_pc_wrap();
        test_fault();
        test_reset_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
